// File: rtl/fifo_reader_pkg.sv
// Shared defaults and width helpers for the FIFO stream reader.
// Optional word counter is enabled by defining FIFO_READER_COUNT_EN.
package fifo_reader_pkg;

    localparam int DEF_DATA_W    = 3;
    localparam int DEF_BUF_DEPTH = 2;

    // Width needed to hold a count of 0..depth.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int OCC_W = occ_w(DEF_BUF_DEPTH);
    localparam int PTR_W = ptr_w(DEF_BUF_DEPTH);

endpackage

// File: rtl/reader_skid_buf.sv
// Circular output buffer for the FIFO stream reader: push at tail, pop at head,
// occupancy count. Head reads as zero while the buffer is empty.
module reader_skid_buf
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [occ_w(DEPTH)-1:0]  occ
);

    localparam int PW = ptr_w(DEPTH);
    localparam int OW = occ_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wrap_inc(wr_ptr);
            if (pop)  rd_ptr <= wrap_inc(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= push_data;
    end

    assign head = (occ != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a synchronous FIFO (1-cycle read latency) and re-presents words on a
// valid/ready stream. Define FIFO_READER_COUNT_EN to add word_count_o.
module fifo_stream_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset_i,
    input  logic                         enable_i,
    input  logic                         fifo_empty_i,
    input  logic [DATA_W-1:0]            fifo_data_i,
    output logic                         fifo_rd_en_o,
    output logic [DATA_W-1:0]            data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [occ_w(BUF_DEPTH)-1:0]  level_o
`ifdef FIFO_READER_COUNT_EN
    ,
    output logic [15:0]                  word_count_o
`endif
);

    localparam int LW = occ_w(BUF_DEPTH);

    logic          inflight;
    logic          pop_out;
    logic [LW:0]   committed;

    assign valid_o = (level_o != '0);
    assign pop_out = valid_o && ready_i;

    // Slots already spoken for once this cycle's handshake completes.
    assign committed = {1'b0, level_o} + {{LW{1'b0}}, inflight} - {{LW{1'b0}}, pop_out};

    assign fifo_rd_en_o = !reset_i && enable_i && !fifo_empty_i &&
                          (committed < (LW + 1)'(BUF_DEPTH));

    always_ff @(posedge clk) begin
        if (reset_i) inflight <= 1'b0;
        else         inflight <= fifo_rd_en_o;
    end

    reader_skid_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (reset_i),
        .push      (inflight),
        .push_data (fifo_data_i),
        .pop       (pop_out),
        .head      (data_o),
        .occ       (level_o)
    );

`ifdef FIFO_READER_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset_i)      word_count_o <= '0;
        else if (pop_out) word_count_o <= word_count_o + 16'd1;
    end
`endif

endmodule
